// File: rtl/sram_arbiter.sv
// sram_arbiter: instruction/data two-master arbiter onto one SRAM-like bus, one transaction in flight.
// Define ARB_RR_EN for round-robin arbitration on contention; default build uses fixed data-side priority.
module sram_arbiter #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          reset,

   input  logic          inst_req,
   input  logic          inst_wr,
   input  logic [1:0]    inst_size,
   input  logic [DW-1:0] inst_addr,
   input  logic [3:0]    inst_wstrb,
   input  logic [DW-1:0] inst_wdata,
   output logic          inst_addr_ok,
   output logic          inst_data_ok,
   output logic [DW-1:0] inst_rdata,

   input  logic          data_req,
   input  logic          data_wr,
   input  logic [1:0]    data_size,
   input  logic [DW-1:0] data_addr,
   input  logic [3:0]    data_wstrb,
   input  logic [DW-1:0] data_wdata,
   output logic          data_addr_ok,
   output logic          data_data_ok,
   output logic [DW-1:0] data_rdata,

   output logic          bus_req,
   output logic          bus_wr,
   output logic [1:0]    bus_size,
   output logic [DW-1:0] bus_addr,
   output logic [3:0]    bus_wstrb,
   output logic [DW-1:0] bus_wdata,
   input  logic          bus_addr_ok,
   input  logic          bus_data_ok,
   input  logic [DW-1:0] bus_rdata
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

   state_t state;
   state_t state_next;
   logic   owner;       // 1: the data side owns the in-flight transaction
   logic   grant;
   logic   grant_data;

`ifdef ARB_RR_EN
   logic   last_data;   // 1: the most recent grant went to the data side
   // On contention the side that was not granted last wins.
   assign grant_data = data_req && (!inst_req || !last_data);
`else
   assign grant_data = data_req;
`endif

   assign inst_rdata = bus_rdata;
   assign data_rdata = bus_rdata;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state plus the combinational accept/completion strobes; all strobes held low during reset.
   always_comb begin
      state_next   = state;
      grant        = 1'b0;
      inst_addr_ok = 1'b0;
      data_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      data_data_ok = 1'b0;
      if (reset) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (inst_req || data_req) begin
                  grant        = 1'b1;
                  inst_addr_ok = !grant_data;
                  data_addr_ok = grant_data;
                  state_next   = REQ;
               end else begin
                  state_next = IDLE;
               end
            end
            REQ: begin
               if (bus_addr_ok) begin
                  state_next = WAIT;
               end else begin
                  state_next = REQ;
               end
            end
            WAIT: begin
               // Completion is only honoured here; earlier bus_data_ok pulses are ignored.
               if (bus_data_ok) begin
                  inst_data_ok = !owner;
                  data_data_ok = owner;
                  state_next   = IDLE;
               end else begin
                  state_next = WAIT;
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // Bus request registers: latched from the winner on grant, request dropped once the bus accepts.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus_req   <= 1'b0;
         bus_wr    <= 1'b0;
         bus_size  <= 2'd0;
         bus_addr  <= {DW{1'b0}};
         bus_wstrb <= 4'd0;
         bus_wdata <= {DW{1'b0}};
         owner     <= 1'b1;
`ifdef ARB_RR_EN
         last_data <= 1'b0;
`endif
      end else begin
         if (grant) begin
            bus_req   <= 1'b1;
            bus_wr    <= grant_data ? data_wr    : inst_wr;
            bus_size  <= grant_data ? data_size  : inst_size;
            bus_addr  <= grant_data ? data_addr  : inst_addr;
            bus_wstrb <= grant_data ? data_wstrb : inst_wstrb;
            bus_wdata <= grant_data ? data_wdata : inst_wdata;
            owner     <= grant_data;
`ifdef ARB_RR_EN
            last_data <= grant_data;
`endif
         end else if (state == REQ && bus_addr_ok) begin
            bus_req <= 1'b0;
         end else begin
            bus_req <= bus_req;
         end
      end
   end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 32, as the data and address width of all request and response buses.
REQ-002 The block SHALL have clk  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have inst_req/inst_wr/inst_size/inst_addr/inst_wstrb/inst_wdata  input  1/1/2/DW/4/DW  instruction-side request.
REQ-005 The block SHALL have inst_addr_ok/inst_data_ok/inst_rdata  output  1/1/DW  instruction-side accept, completion and read data.
REQ-006 The block SHALL have data_req/data_wr/data_size/data_addr/data_wstrb/data_wdata  input  1/1/2/DW/4/DW  data-side request.
REQ-007 The block SHALL have data_addr_ok/data_data_ok/data_rdata  output  1/1/DW  data-side accept, completion and read data.
REQ-008 The block SHALL have bus_req/bus_wr/bus_size/bus_addr/bus_wstrb/bus_wdata  output  1/1/2/DW/4/DW  shared SRAM-like bus request, all driven from registers.
REQ-009 The block SHALL have bus_addr_ok/bus_data_ok/bus_rdata  input  1/1/DW  shared bus accept, completion and read data.

Function
REQ-010 The block SHALL implement the FSM states IDLE, REQ and WAIT, with at most one transaction outstanding on the bus.
REQ-011 In IDLE with at least one requester active, the block SHALL select a winner, pulse that side's addr_ok for one cycle, and latch the winner's wr, size, addr, wstrb and wdata into the bus registers and an owner flag; the next state SHALL be REQ.
REQ-012 In IDLE, the addr_ok of the losing side SHALL stay 0, and the losing request SHALL remain pending until it is granted.
REQ-013 In REQ, bus_req SHALL be 1 with stable fields; on bus_addr_ok=1, bus_req SHALL fall the next cycle and the state SHALL move to WAIT.
REQ-014 In WAIT, bus_req SHALL be 0; on bus_data_ok=1, the owner's data_ok SHALL be 1 combinationally in that same cycle, and the state SHALL return to IDLE.
REQ-015 inst_rdata and data_rdata SHALL both equal bus_rdata at all times; the data_ok signals alone qualify them.
REQ-016 bus_data_ok received in IDLE or REQ SHALL be ignored, and no data_ok SHALL be asserted in those states.
REQ-017 Minimum per-transaction occupancy SHALL be 3 cycles (IDLE grant, REQ, WAIT); the earliest next grant SHALL occur in the IDLE cycle after completion.
REQ-018 Without RR, a simultaneous inst_req and data_req SHALL always grant the data side.
REQ-019 The block SHALL not modify bus_wdata, bus_wstrb or bus_size; they SHALL pass through unchanged from the latch.

Reset
REQ-020 Reset SHALL immediately force state IDLE, bus_req=0, bus_wr=0, bus_size=0, bus_addr=0, bus_wstrb=0, bus_wdata=0, owner=data and last-grant=inst.
REQ-021 During reset, all addr_ok and data_ok outputs SHALL be 0.
REQ-022 A transaction interrupted mid-operation by reset SHALL be abandoned, with no data_ok issued for it.

Configuration
REQ-023 When ARB_RR_EN is defined, the block SHALL add a last-grant register; a simultaneous request SHALL grant the side not granted last, and the register SHALL update on every grant.
REQ-024 When ARB_RR_EN is undefined, the block SHALL omit the last-grant register and use fixed data-side priority per REQ-018.

Verification
REQ-025 Single read: inst_req=1 with addr 0x1C000000 and bus_addr_ok=1 immediately -> inst_addr_ok in cycle 0, bus_req in cycle 1 with addr 0x1C000000, and inst_data_ok with rdata 0x12345678 in the cycle bus_data_ok=1.
REQ-026 Write stall: data_req=1 with wr=1, wstrb=0x3, wdata 0xDEADBEEF and bus_addr_ok held 0 for 4 cycles -> bus_req stays 1 for 5 cycles with fields stable, and no second grant occurs.
REQ-027 Contention, macro undefined: inst_req and data_req both held 1 -> the data side wins every grant, and inst_addr_ok never asserts while data_req is held.
REQ-028 Contention, ARB_RR_EN defined: both requests held for 4 transactions -> the grant sequence is data, inst, data, inst.
REQ-029 Reset in WAIT: assert reset for 1 cycle before bus_data_ok -> bus_req=0 asynchronously, no data_ok is issued, and a new inst_req is granted in the first cycle after reset release.
REQ-030 Spurious completion: bus_data_ok=1 while in IDLE -> both data_ok outputs stay 0 and the state is unchanged.
